// File: rtl/call_stack.sv
// call_stack: hardware return stack for CALL/RET.
// Each entry holds {return PC, flags}. The top entry is shown combinationally
// on out_pc/out_flags (zero when empty), so a pop strobe sees the old top in
// the same cycle. Overflow/underflow enter a sticky FAULT state that leaves
// storage and the stack pointer untouched until in_clear_fault.
// Optional feature: define CALL_STACK_WATERMARK_EN to add out_watermark, the
// maximum depth reached since reset.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8,
  parameter int FLG_W = 4,
  localparam int DW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_push_en,
  input  logic             in_pop_en,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [FLG_W-1:0] in_flags,
  input  logic             in_clear_fault,
  output logic [PC_W-1:0]  out_pc,
  output logic [FLG_W-1:0] out_flags,
  output logic [DW-1:0]    out_depth,
  output logic             out_empty,
  output logic             out_full,
  output logic             out_fault
`ifdef CALL_STACK_WATERMARK_EN
  ,
  output logic [DW-1:0]    out_watermark
`endif
);

  // Slot index width; DEPTH is a power of two >= 2, so this is exact.
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] SP_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] SP_ONE = DW'(1);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ACTIVE = 2'd1,
    S_FULL   = 2'd2,
    S_FAULT  = 2'd3
  } state_t;

  state_t            state_reg;
  logic [DW-1:0]     sp_reg;      // next free slot == current depth
  logic [PC_W-1:0]   pc_mem  [DEPTH];
  logic [FLG_W-1:0]  flg_mem [DEPTH];

  logic [DW-1:0]     sp_dec;
  logic [AW-1:0]     top_idx;
  logic              is_empty;
  logic              is_full;
  logic              op_allowed;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;

  // State to resume in when leaving FAULT, chosen from the frozen depth.
  function automatic state_t depth_state(input logic [DW-1:0] sp);
    if (sp == '0)
      return S_EMPTY;
    else if (sp == SP_MAX)
      return S_FULL;
    else
      return S_ACTIVE;
  endfunction

  assign sp_dec     = sp_reg - SP_ONE;
  assign top_idx    = sp_dec[AW-1:0];
  assign is_empty   = (sp_reg == '0);
  assign is_full    = (sp_reg == SP_MAX);
  assign op_allowed = (state_reg != S_FAULT);

  // Storage write: a plain push fills slot sp, push+pop rewrites the top slot.
  // The guards make sure a faulting operation never writes.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sp_reg[AW-1:0];
    if (op_allowed && in_push_en) begin
      if (in_pop_en) begin
        wr_en  = !is_empty;
        wr_idx = top_idx;
      end else begin
        wr_en  = !is_full;
      end
    end
  end

  // Entry storage; contents survive reset, a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      pc_mem[wr_idx]  <= in_pc;
      flg_mem[wr_idx] <= in_flags;
    end
  end

  // Stack pointer and EMPTY/ACTIVE/FULL/FAULT control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_EMPTY;
      sp_reg    <= '0;
    end else begin
      case (state_reg)
        S_FAULT: begin
          // Clear wins; any same-cycle strobe is ignored.
          if (in_clear_fault)
            state_reg <= depth_state(sp_reg);
        end
        default: begin
          if (in_push_en && in_pop_en) begin
            // Replace top in place; with nothing to replace it is an underflow.
            if (is_empty)
              state_reg <= S_FAULT;
          end else if (in_push_en) begin
            if (is_full) begin
              state_reg <= S_FAULT;
            end else begin
              sp_reg    <= sp_reg + SP_ONE;
              state_reg <= ((sp_reg + SP_ONE) == SP_MAX) ? S_FULL : S_ACTIVE;
            end
          end else if (in_pop_en) begin
            if (is_empty) begin
              state_reg <= S_FAULT;
            end else begin
              sp_reg    <= sp_dec;
              state_reg <= (sp_reg == SP_ONE) ? S_EMPTY : S_ACTIVE;
            end
          end
        end
      endcase
    end
  end

`ifdef CALL_STACK_WATERMARK_EN
  logic [DW-1:0] wm_reg;

  // Track the deepest point reached; only a successful plain push grows depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wm_reg <= '0;
    end else if (op_allowed && in_push_en && !in_pop_en && !is_full &&
                 ((sp_reg + SP_ONE) > wm_reg)) begin
      wm_reg <= sp_reg + SP_ONE;
    end
  end

  assign out_watermark = wm_reg;
`endif

  assign out_pc    = is_empty ? '0 : pc_mem[top_idx];
  assign out_flags = is_empty ? '0 : flg_mem[top_idx];
  assign out_depth = sp_reg;
  assign out_empty = is_empty;
  assign out_full  = is_full;
  assign out_fault = (state_reg == S_FAULT);

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: directed scenarios with literal expectations, then a
// randomized run checked every cycle against a queue-based stack model.
module tb_call_stack;

  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_push_en = 1'b0;
  logic       in_pop_en = 1'b0;
  logic [7:0] in_pc = '0;
  logic [3:0] in_flags = '0;
  logic       in_clear_fault = 1'b0;
  logic [7:0] out_pc;
  logic [3:0] out_flags;
  logic [DW-1:0] out_depth;
  logic       out_empty;
  logic       out_full;
  logic       out_fault;
`ifdef CALL_STACK_WATERMARK_EN
  logic [DW-1:0] out_watermark;
`endif

  call_stack #(.DEPTH(DEPTH), .PC_W(8), .FLG_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_push_en     (in_push_en),
    .in_pop_en      (in_pop_en),
    .in_pc          (in_pc),
    .in_flags       (in_flags),
    .in_clear_fault (in_clear_fault),
    .out_pc         (out_pc),
    .out_flags      (out_flags),
    .out_depth      (out_depth),
    .out_empty      (out_empty),
    .out_full       (out_full),
    .out_fault      (out_fault)
`ifdef CALL_STACK_WATERMARK_EN
    ,
    .out_watermark  (out_watermark)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a queue of {pc,flags}, a fault flag and a high-water mark.
  logic [11:0] m_q[$];
  bit          m_fault;
  int          m_wm;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_fault = 1'b0;
    m_wm    = 0;
  endfunction

  function automatic void model_step(input bit p, input bit o, input logic [7:0] pc,
                                     input logic [3:0] fl, input bit c);
    if (m_fault) begin
      if (c) m_fault = 1'b0;
    end else if (p && o) begin
      if (m_q.size() == 0) m_fault = 1'b1;
      else m_q[m_q.size()-1] = {pc, fl};
    end else if (p) begin
      if (m_q.size() == DEPTH) m_fault = 1'b1;
      else m_q.push_back({pc, fl});
    end else if (o) begin
      if (m_q.size() == 0) m_fault = 1'b1;
      else void'(m_q.pop_back());
    end
    if (m_q.size() > m_wm) m_wm = m_q.size();
  endfunction

  function automatic void check_all();
    int d;
    logic [11:0] top;
    d   = m_q.size();
    top = (d == 0) ? 12'h000 : m_q[d-1];
    chk("depth", int'(out_depth), d);
    chk("empty", int'(out_empty), int'(d == 0));
    chk("full",  int'(out_full),  int'(d == DEPTH));
    chk("fault", int'(out_fault), int'(m_fault));
    chk("pc",    int'(out_pc),    int'(top[11:4]));
    chk("flags", int'(out_flags), int'(top[3:0]));
`ifdef CALL_STACK_WATERMARK_EN
    chk("watermark", int'(out_watermark), m_wm);
`endif
  endfunction

  // One clock cycle: drive, compare mid-cycle against the model, then clock both.
  task automatic step(input bit p, input bit o, input logic [7:0] pc,
                      input logic [3:0] fl, input bit c);
    in_push_en = p; in_pop_en = o; in_pc = pc; in_flags = fl; in_clear_fault = c;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step(p, o, pc, fl, c);
    #1;
    $display("cyc push=%0b pop=%0b clr=%0b pc=%02h fl=%0h -> depth=%0d pc=%02h fault=%0b",
             p, o, c, pc, fl, out_depth, out_pc, out_fault);
  endtask

  task automatic do_reset();
    in_push_en = 0; in_pop_en = 0; in_clear_fault = 0;
    rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_empty", int'(out_empty), 1);
    chk("rst_depth", int'(out_depth), 0);
    chk("rst_pc",    int'(out_pc),    0);
    chk("rst_fault", int'(out_fault), 0);

    // Scenario 1: two pushes then a pop.
    step(1, 0, 8'h12, 4'h3, 0);
    step(1, 0, 8'h34, 4'hA, 0);
    chk("t1_depth", int'(out_depth), 2);
    chk("t1_pc",    int'(out_pc),    8'h34);
    chk("t1_flags", int'(out_flags), 4'hA);
    in_pop_en = 1'b1;
    #1;
    chk("t1_pc_during_pop", int'(out_pc), 8'h34);
    step(0, 1, 8'h00, 4'h0, 0);
    chk("t1_pc_after_pop", int'(out_pc), 8'h12);

    // Scenario 2: fill, then overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), 4'(i), 0);
    chk("t2_full", int'(out_full), 1);
    step(1, 0, 8'hEE, 4'hE, 0);
    chk("t2_fault", int'(out_fault), 1);
    chk("t2_depth", int'(out_depth), 8);
    chk("t2_pc",    int'(out_pc),    7);
    step(0, 1, 8'h00, 4'h0, 0);   // ignored while faulted
    chk("t2_frozen", int'(out_depth), 8);

    // Scenario 3: underflow then clear.
    do_reset();
    step(0, 1, 8'h00, 4'h0, 0);
    chk("t3_fault", int'(out_fault), 1);
    chk("t3_depth", int'(out_depth), 0);
    chk("t3_pc",    int'(out_pc),    0);
    step(1, 0, 8'h99, 4'h9, 1);   // clear wins, push ignored
    chk("t3_cleared", int'(out_fault), 0);
    chk("t3_empty",   int'(out_empty), 1);

    // Scenario 4: replace top in place.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 8'hA0 + 8'(i), 4'(i), 0);
    step(1, 1, 8'h55, 4'h5, 0);
    chk("t4_depth", int'(out_depth), 3);
    chk("t4_pc",    int'(out_pc),    8'h55);
    step(0, 1, 8'h00, 4'h0, 0);
    chk("t4_below1", int'(out_pc), 8'hA1);
    step(0, 1, 8'h00, 4'h0, 0);
    chk("t4_below0", int'(out_pc), 8'hA0);

    // Scenario 5: asynchronous reset between edges.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 8'h10 + 8'(i), 4'h1, 0);
    chk("t5_pre", int'(out_depth), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_depth", int'(out_depth), 0);
    chk("t5_async_empty", int'(out_empty), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef CALL_STACK_WATERMARK_EN
    // Scenario 6: watermark.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 8'(i), 4'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 4'h0, 0);
    step(1, 0, 8'h77, 4'h7, 0);
    chk("t6_wm", int'(out_watermark), 5);
    do_reset();
    chk("t6_wm_rst", int'(out_watermark), 0);
`endif

    // Randomized phase.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      int r;
      bit p, o, c;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        do_reset();
      end else begin
        p = ($urandom_range(0, 99) < 50);
        o = ($urandom_range(0, 99) < 45);
        c = ($urandom_range(0, 99) < 15);
        step(p, o, 8'($urandom), 4'($urandom), c);
      end
    end
    @(negedge clk);
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
